// File: rtl/hms_record_feeder_pkg.sv
// ----------------------------------------------------------------------------
// hms_record_feeder_pkg
// Shared constants and types for the E-record merge feeder.
//   BLKW         : width of one block (E records of DATW bits)
//   SENTINEL_KEY : key value that marks the end of a stream
//   state_t      : feeder sequencing states
//   lead_key     : extracts the leading key (record 0) of a block
// ----------------------------------------------------------------------------
package hms_record_feeder_pkg;

   localparam int E_LOG     = 2;
   localparam int DATW      = 64;
   localparam int KEYW      = 32;
   localparam int FIFO_SIZE = 4;

   localparam int BLKW = DATW << E_LOG;

   localparam logic [KEYW-1:0] SENTINEL_KEY = {KEYW{1'b1}};

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      FIN   = 2'd2
   } state_t;

   // Leading key of a block: record 0, low KEYW bits.
   function automatic logic [KEYW-1:0] lead_key(input logic [BLKW-1:0] blk);
      return blk[KEYW-1:0];
   endfunction

endpackage

// File: rtl/hms_record_feeder_srl_fifo.sv
// ----------------------------------------------------------------------------
// SRL_FIFO
// Shift-register FIFO. New entries shift in at slot 0; the oldest entry sits
// at slot cnt-1, so the head is read through a pointer derived from the count.
// Ports:
//   CLK  : clock
//   RST  : synchronous, active-high reset (empties the FIFO)
//   enq  : push din (ignored when the FIFO already holds 1<<FIFO_SIZE entries)
//   din  : data to push
//   deq  : pop the head (ignored when empty)
//   dot  : current head entry
//   emp  : registered empty flag
//   full : registered flag, set when the count is at or above depth-1
// ----------------------------------------------------------------------------
module SRL_FIFO #(
   parameter int FIFO_SIZE  = 4,
   parameter int FIFO_WIDTH = 256
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  enq,
   input  logic [FIFO_WIDTH-1:0] din,
   input  logic                  deq,
   output logic [FIFO_WIDTH-1:0] dot,
   output logic                  emp,
   output logic                  full
);
   import hms_record_feeder_pkg::*;

   localparam int DEPTH = 1 << FIFO_SIZE;
   localparam logic [FIFO_SIZE:0] DEPTH_C  = (FIFO_SIZE+1)'(DEPTH);
   localparam logic [FIFO_SIZE:0] FULL_LVL = (FIFO_SIZE+1)'(DEPTH - 1);
   localparam logic [FIFO_SIZE:0] CNT_ONE  = (FIFO_SIZE+1)'(1);
   localparam logic [FIFO_SIZE-1:0] IDX_ONE = (FIFO_SIZE)'(1);

   logic [FIFO_WIDTH-1:0] mem_r [DEPTH];
   logic [FIFO_SIZE:0]    cnt_r;
   logic [FIFO_SIZE:0]    cnt_next_s;
   logic                  emp_r;
   logic                  full_r;
   logic                  enq_ok_s;
   logic                  deq_ok_s;
   logic [FIFO_SIZE-1:0]  head_idx_s;

   assign enq_ok_s = enq && (cnt_r != DEPTH_C);
   assign deq_ok_s = deq && (cnt_r != {(FIFO_SIZE+1){1'b0}});

   // Head lives at slot cnt-1; a count of DEPTH wraps to slot DEPTH-1.
   assign head_idx_s = cnt_r[FIFO_SIZE-1:0] - IDX_ONE;
   assign dot        = mem_r[head_idx_s];
   assign emp        = emp_r;
   assign full       = full_r;

   // Next occupancy; simultaneous push and pop leave the count unchanged.
   always_comb begin
      cnt_next_s = cnt_r;
      case ({enq_ok_s, deq_ok_s})
         2'b10:   cnt_next_s = cnt_r + CNT_ONE;
         2'b01:   cnt_next_s = cnt_r - CNT_ONE;
         default: cnt_next_s = cnt_r;
      endcase
   end

   // Storage shift chain; payload needs no reset since the count qualifies it.
   always_ff @(posedge CLK) begin
      if (enq_ok_s) begin
         for (int i = DEPTH - 1; i > 0; i--) begin
            mem_r[i] <= mem_r[i-1];
         end
         mem_r[0] <= din;
      end
   end

   // Occupancy and the registered status flags.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_r  <= {(FIFO_SIZE+1){1'b0}};
         emp_r  <= 1'b1;
         full_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_next_s;
         emp_r  <= (cnt_next_s == {(FIFO_SIZE+1){1'b0}});
         full_r <= (cnt_next_s >= FULL_LVL);
      end
   end

endmodule

// File: rtl/hms_record_feeder.sv
// ----------------------------------------------------------------------------
// hms_record_feeder
// Upstream initiator for the E-record merge network. Buffers two sorted
// block streams, issues the head block with the smaller leading key each
// unstalled cycle (ties to stream 0), then on both end-of-stream sentinels
// emits one all-ones flush block and raises DONE.
// Ports:
//   CLK    : clock
//   RST    : synchronous active-low reset
//   STALL  : downstream stall; holds outputs and blocks dequeues
//   DIN0/DIN0EN, FULL0 : stream 0 block input, enqueue, almost-full
//   DIN1/DIN1EN, FULL1 : stream 1 block input, enqueue, almost-full
//   DOT/DOTEN : registered block output and its valid
//   DONE   : sticky completion flag
// ----------------------------------------------------------------------------
module hms_record_feeder #(
   parameter int E_LOG     = hms_record_feeder_pkg::E_LOG,
   parameter int DATW      = hms_record_feeder_pkg::DATW,
   parameter int KEYW      = hms_record_feeder_pkg::KEYW,
   parameter int FIFO_SIZE = hms_record_feeder_pkg::FIFO_SIZE
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       STALL,
   input  logic [(DATW<<E_LOG)-1:0]   DIN0,
   input  logic                       DIN0EN,
   output logic                       FULL0,
   input  logic [(DATW<<E_LOG)-1:0]   DIN1,
   input  logic                       DIN1EN,
   output logic                       FULL1,
   output logic [(DATW<<E_LOG)-1:0]   DOT,
   output logic                       DOTEN,
   output logic                       DONE
);
   import hms_record_feeder_pkg::*;

   localparam int BLK_W = DATW << E_LOG;
   localparam logic [KEYW-1:0] SENT_K = {KEYW{1'b1}};

   state_t             state_r;
   state_t             state_next_s;
   logic [BLK_W-1:0]   dot_r;
   logic [BLK_W-1:0]   dot_next_s;
   logic               doten_r;
   logic               doten_next_s;
   logic               done_r;
   logic               done_next_s;

   logic [BLK_W-1:0]   head0_s;
   logic [BLK_W-1:0]   head1_s;
   logic               emp0_s;
   logic               emp1_s;
   logic               enq0_s;
   logic               enq1_s;
   logic               deq0_s;
   logic               deq1_s;
   logic [KEYW-1:0]    hk0_s;
   logic [KEYW-1:0]    hk1_s;
   logic               sent0_s;
   logic               sent1_s;

   // Once finished, new blocks are dropped so stale data cannot leak out
   // before the next reset.
   assign enq0_s = DIN0EN && (state_r != FIN);
   assign enq1_s = DIN1EN && (state_r != FIN);

   SRL_FIFO #(
      .FIFO_SIZE  (FIFO_SIZE),
      .FIFO_WIDTH (BLK_W)
   ) u_fifo0 (
      .CLK  (CLK),
      .RST  (~RST),
      .enq  (enq0_s),
      .din  (DIN0),
      .deq  (deq0_s),
      .dot  (head0_s),
      .emp  (emp0_s),
      .full (FULL0)
   );

   SRL_FIFO #(
      .FIFO_SIZE  (FIFO_SIZE),
      .FIFO_WIDTH (BLK_W)
   ) u_fifo1 (
      .CLK  (CLK),
      .RST  (~RST),
      .enq  (enq1_s),
      .din  (DIN1),
      .deq  (deq1_s),
      .dot  (head1_s),
      .emp  (emp1_s),
      .full (FULL1)
   );

   assign hk0_s   = head0_s[KEYW-1:0];
   assign hk1_s   = head1_s[KEYW-1:0];
   assign sent0_s = (hk0_s == SENT_K);
   assign sent1_s = (hk1_s == SENT_K);

   // Selection and sequencing. A sentinel head never wins against a real key
   // because real keys are strictly below all-ones, so only the
   // both-sentinel case needs explicit handling.
   always_comb begin
      state_next_s = state_r;
      dot_next_s   = dot_r;
      doten_next_s = doten_r;
      done_next_s  = done_r;
      deq0_s       = 1'b0;
      deq1_s       = 1'b0;
      if (!STALL) begin
         case (state_r)
            RUN: begin
               if (emp0_s || emp1_s) begin
                  doten_next_s = 1'b0;
               end else if (sent0_s && sent1_s) begin
                  deq0_s       = 1'b1;
                  deq1_s       = 1'b1;
                  doten_next_s = 1'b0;
                  state_next_s = FLUSH;
               end else if (hk0_s <= hk1_s) begin
                  dot_next_s   = head0_s;
                  doten_next_s = 1'b1;
                  deq0_s       = 1'b1;
               end else begin
                  dot_next_s   = head1_s;
                  doten_next_s = 1'b1;
                  deq1_s       = 1'b1;
               end
            end
            FLUSH: begin
               dot_next_s   = {BLK_W{1'b1}};
               doten_next_s = 1'b1;
               state_next_s = FIN;
            end
            FIN: begin
               doten_next_s = 1'b0;
               done_next_s  = 1'b1;
            end
            default: begin
               doten_next_s = 1'b0;
               state_next_s = RUN;
            end
         endcase
      end else begin
         state_next_s = state_r;
         dot_next_s   = dot_r;
         doten_next_s = doten_r;
      end
   end

   // State and output registers.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_r <= RUN;
         dot_r   <= {BLK_W{1'b0}};
         doten_r <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         dot_r   <= dot_next_s;
         doten_r <= doten_next_s;
         done_r  <= done_next_s;
      end
   end

   assign DOT   = dot_r;
   assign DOTEN = doten_r;
   assign DONE  = done_r;

endmodule

// File: tb/tb_hms_record_feeder.sv
// ----------------------------------------------------------------------------
// tb_hms_record_feeder
// Scoreboard bench: the expected output sequence of each scenario is the
// plain sorted merge of the two source streams (ties to stream 0, sentinels
// excluded) followed by one all-ones flush block. A monitor pops and compares
// every new DOTEN beat independently of the stimulus.
// ----------------------------------------------------------------------------
module tb_hms_record_feeder;
   import hms_record_feeder_pkg::*;

   localparam logic [BLKW-1:0] FLUSH_BLK = {BLKW{1'b1}};

   logic            CLK = 1'b0;
   logic            RST = 1'b0;
   logic            STALL = 1'b0;
   logic [BLKW-1:0] DIN0 = '0;
   logic            DIN0EN = 1'b0;
   logic            FULL0;
   logic [BLKW-1:0] DIN1 = '0;
   logic            DIN1EN = 1'b0;
   logic            FULL1;
   logic [BLKW-1:0] DOT;
   logic            DOTEN;
   logic            DONE;

   always #5 CLK = ~CLK;

   hms_record_feeder dut (
      .CLK    (CLK),
      .RST    (RST),
      .STALL  (STALL),
      .DIN0   (DIN0),
      .DIN0EN (DIN0EN),
      .FULL0  (FULL0),
      .DIN1   (DIN1),
      .DIN1EN (DIN1EN),
      .FULL1  (FULL1),
      .DOT    (DOT),
      .DOTEN  (DOTEN),
      .DONE   (DONE)
   );

   int              n_vec = 0;
   int              n_err = 0;
   logic [BLKW-1:0] src0[$];
   logic [BLKW-1:0] src1[$];
   logic [BLKW-1:0] exp_q[$];
   logic [BLKW-1:0] last_out = '0;
   int              n_out = 0;
   bit              flush_pending = 1'b0;
   bit              run_active = 1'b0;
   logic            stall_edge = 1'b0;
   logic            rst_edge = 1'b0;

   task automatic check(input string name, input logic [BLKW-1:0] act, input logic [BLKW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [BLKW-1:0] mk(input logic [KEYW-1:0] k0, input logic [KEYW-1:0] k1,
                                          input logic [KEYW-1:0] k2, input logic [KEYW-1:0] k3);
      logic [BLKW-1:0] b;
      b = '0;
      b[0*DATW +: DATW] = {$urandom(), k0};
      b[1*DATW +: DATW] = {$urandom(), k1};
      b[2*DATW +: DATW] = {$urandom(), k2};
      b[3*DATW +: DATW] = {$urandom(), k3};
      return b;
   endfunction

   function automatic logic [BLKW-1:0] sentinel();
      return mk(SENTINEL_KEY, SENTINEL_KEY, SENTINEL_KEY, SENTINEL_KEY);
   endfunction

   // Reference: sorted merge of both streams, then the flush block.
   task automatic build_expected();
      int i = 0;
      int j = 0;
      logic [KEYW-1:0] a;
      logic [KEYW-1:0] b;
      exp_q.delete();
      while (1) begin
         a = lead_key(src0[i]);
         b = lead_key(src1[j]);
         if (a == SENTINEL_KEY && b == SENTINEL_KEY) break;
         if (a <= b) begin exp_q.push_back(src0[i]); i++; end
         else        begin exp_q.push_back(src1[j]); j++; end
      end
      exp_q.push_back(FLUSH_BLK);
   endtask

   task automatic gen_stream(input int n, input int step, output logic [BLKW-1:0] q[$]);
      int k;
      q.delete();
      k = $urandom_range(3, 0);
      for (int b = 0; b < n; b++) begin
         q.push_back(mk(KEYW'(k), KEYW'(k + 1), KEYW'(k + 5), KEYW'(k + 9)));
         k += $urandom_range(step, 0);
      end
      q.push_back(sentinel());
   endtask

   // Monitor: record what the DUT saw at each active edge.
   always @(posedge CLK) begin
      stall_edge <= STALL;
      rst_edge   <= RST;
   end

   // Monitor: after every unstalled, non-reset edge a raised DOTEN is a new beat.
   always @(negedge CLK) begin
      logic [BLKW-1:0] e;
      if (rst_edge && !stall_edge) begin
         if (flush_pending) begin
            check("done_after_flush", DONE, 1'b1);
            check("doten_after_flush", DOTEN, 1'b0);
            flush_pending = 1'b0;
         end
         if (DOTEN) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_output: got %h expected no output", DOT);
            end else begin
               e = exp_q.pop_front();
               check("dot", DOT, e);
               check("done_low_during_stream", DONE, 1'b0);
               last_out = e;
               n_out++;
               if (e == FLUSH_BLK) flush_pending = 1'b1;
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge CLK); #1;
      RST = 1'b0; STALL = 1'b0; DIN0EN = 1'b0; DIN1EN = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      check("rst_dot", DOT, '0);
      check("rst_doten", DOTEN, 1'b0);
      check("rst_done", DONE, 1'b0);
      check("rst_full0", FULL0, 1'b0);
      check("rst_full1", FULL1, 1'b0);
      exp_q.delete();
      flush_pending = 1'b0;
      n_out = 0;
      RST = 1'b1;
   endtask

   task automatic feed0(input int start, input int pct);
      int i = start;
      int c = 0;
      while (i < src0.size() && c < 4000) begin
         @(posedge CLK); #1; c++;
         if (!FULL0 && ($urandom_range(99, 0) < pct)) begin
            DIN0 = src0[i]; DIN0EN = 1'b1; i++;
         end else DIN0EN = 1'b0;
      end
      @(posedge CLK); #1; DIN0EN = 1'b0;
   endtask

   task automatic feed1(input int start, input int pct);
      int i = start;
      int c = 0;
      while (i < src1.size() && c < 4000) begin
         @(posedge CLK); #1; c++;
         if (!FULL1 && ($urandom_range(99, 0) < pct)) begin
            DIN1 = src1[i]; DIN1EN = 1'b1; i++;
         end else DIN1EN = 1'b0;
      end
      @(posedge CLK); #1; DIN1EN = 1'b0;
   endtask

   task automatic stall_rand(input int pct);
      while (run_active) begin
         @(posedge CLK); #1;
         STALL = ($urandom_range(99, 0) < pct);
      end
      STALL = 1'b0;
   endtask

   task automatic wait_done();
      int c = 0;
      while (!DONE && c < 4000) begin
         @(negedge CLK); c++;
      end
      run_active = 1'b0;
      check("done_reached", DONE, 1'b1);
   endtask

   task automatic finish_run();
      @(negedge CLK); #1;
      check("scoreboard_drained", exp_q.size(), 0);
      check("flush_done_checked", flush_pending, 1'b0);
   endtask

   task automatic run_merge(input int feed_pct, input int stall_pct);
      build_expected();
      run_active = 1'b1;
      fork
         feed0(0, feed_pct);
         feed1(0, feed_pct);
         stall_rand(stall_pct);
         wait_done();
      join
      finish_run();
   endtask

   initial begin
      int c;
      int saved;

      // Basic merge from the worked example.
      do_reset();
      src0.delete(); src1.delete();
      src0.push_back(mk(32'd1, 32'd3, 32'd5, 32'd7));
      src0.push_back(mk(32'd9, 32'd11, 32'd13, 32'd15));
      src0.push_back(sentinel());
      src1.push_back(mk(32'd2, 32'd4, 32'd6, 32'd8));
      src1.push_back(sentinel());
      run_merge(100, 0);
      // Enqueues after DONE are ignored: no output, DONE stays.
      @(posedge CLK); #1;
      DIN0 = mk(32'd1, 32'd2, 32'd3, 32'd4); DIN0EN = 1'b1;
      DIN1 = mk(32'd2, 32'd2, 32'd3, 32'd4); DIN1EN = 1'b1;
      @(posedge CLK); #1; DIN0EN = 1'b0; DIN1EN = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         check("fin_doten_low", DOTEN, 1'b0);
         check("fin_done_sticky", DONE, 1'b1);
      end

      // Tie: stream 0 wins.
      do_reset();
      src0.delete(); src1.delete();
      src0.push_back(mk(32'd5, 32'd6, 32'd7, 32'd8));
      src0.push_back(sentinel());
      src1.push_back(mk(32'd5, 32'd9, 32'd9, 32'd9));
      src1.push_back(sentinel());
      run_merge(100, 0);

      // Stall freeze for three cycles while DOTEN is high.
      do_reset();
      src0.delete(); src1.delete();
      src0.push_back(mk(32'd10, 32'd11, 32'd12, 32'd13));
      src0.push_back(mk(32'd30, 32'd31, 32'd32, 32'd33));
      src0.push_back(mk(32'd50, 32'd51, 32'd52, 32'd53));
      src0.push_back(sentinel());
      src1.push_back(mk(32'd20, 32'd21, 32'd22, 32'd23));
      src1.push_back(mk(32'd40, 32'd41, 32'd42, 32'd43));
      src1.push_back(mk(32'd60, 32'd61, 32'd62, 32'd63));
      src1.push_back(sentinel());
      build_expected();
      @(posedge CLK); #1; STALL = 1'b1;
      for (int i = 0; i < 4; i++) begin
         DIN0 = src0[i]; DIN0EN = 1'b1; DIN1 = src1[i]; DIN1EN = 1'b1;
         @(posedge CLK); #1;
      end
      DIN0EN = 1'b0; DIN1EN = 1'b0;
      STALL = 1'b0;
      c = 0;
      while (n_out < 2 && c < 100) begin
         @(negedge CLK); #1; c++;
      end
      check("stall_setup_outputs", n_out, 2);
      STALL = 1'b1;
      saved = n_out;
      repeat (3) begin
         @(negedge CLK); #1;
         check("stall_dot_frozen", DOT, last_out);
         check("stall_doten_frozen", DOTEN, 1'b1);
         check("stall_no_new_beat", n_out, saved);
      end
      STALL = 1'b0;
      wait_done();
      finish_run();

      // Back-pressure: 15 blocks into stream 0 while stalled.
      do_reset();
      src0.delete(); src1.delete();
      for (int i = 0; i < 15; i++) src0.push_back(mk(KEYW'(2 * i), 32'd100, 32'd101, 32'd102));
      src0.push_back(sentinel());
      src1.push_back(mk(32'd1000, 32'd1001, 32'd1002, 32'd1003));
      src1.push_back(sentinel());
      build_expected();
      @(posedge CLK); #1;
      STALL = 1'b1;
      DIN1 = src1[0]; DIN1EN = 1'b1;
      DIN0 = src0[0]; DIN0EN = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         @(posedge CLK); #1;
         check("full0_fill", FULL0, (i >= 15) ? 1'b1 : 1'b0);
         check("full1_fill", FULL1, 1'b0);
         DIN1EN = 1'b0;
         if (i < 15) DIN0 = src0[i];
         else DIN0EN = 1'b0;
      end
      STALL = 1'b0;
      @(posedge CLK); #1;
      check("full0_release", FULL0, 1'b0);
      fork
         feed0(15, 100);
         feed1(1, 100);
      join
      wait_done();
      finish_run();

      // One stream holds only its sentinel.
      do_reset();
      gen_stream(3, 4, src0);
      src1.delete();
      src1.push_back(sentinel());
      run_merge(70, 30);

      // Reset mid-operation after two outputs.
      do_reset();
      gen_stream(6, 3, src0);
      gen_stream(6, 3, src1);
      build_expected();
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         DIN0 = src0[i]; DIN0EN = 1'b1; DIN1 = src1[i]; DIN1EN = 1'b1;
      end
      @(posedge CLK); #1; DIN0EN = 1'b0; DIN1EN = 1'b0;
      c = 0;
      while (n_out < 2 && c < 100) begin
         @(negedge CLK); #1; c++;
      end
      check("midrst_outputs_seen", (n_out >= 2) ? 1'b1 : 1'b0, 1'b1);
      do_reset();
      gen_stream(5, 2, src0);
      gen_stream(4, 2, src1);
      run_merge(80, 20);

      // Randomized runs, including tie-heavy key steps and heavy stalling.
      for (int r = 0; r < 6; r++) begin
         do_reset();
         gen_stream($urandom_range(20, 0), $urandom_range(3, 0), src0);
         gen_stream($urandom_range(20, 0), $urandom_range(3, 0), src1);
         run_merge($urandom_range(100, 30), $urandom_range(60, 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
